// File: rtl/ppi_pkg.sv
// Shared types for the 8255-style PPI: handshake FSM states and
// the mode encodings also used by the control word register.
package ppi_pkg;

  typedef enum logic [1:0] {
    IN_IDLE,
    IN_CAPT,
    IN_FULL,
    IN_READ
  } in_state_t;

  typedef enum logic [1:0] {
    OUT_IDLE,
    OUT_WRITE,
    OUT_FULL,
    OUT_ACK
  } out_state_t;

  localparam logic [1:0] MODE0 = 2'd0;
  localparam logic [1:0] MODE1 = 2'd1;
  localparam logic [1:0] MODE2 = 2'd2;

endpackage

// File: rtl/ppi_sync_edge.sv
// Pin synchronizer plus registered edge detect for an active-low pin.
// Ports: Clk, Reset, pin_i (async pin) -> level_o, fall_o, rise_o.
module ppi_sync_edge #(
  parameter int SYNC_STAGES = 2
) (
  input  logic Clk,
  input  logic Reset,
  input  logic pin_i,
  output logic level_o,
  output logic fall_o,
  output logic rise_o
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   prev_q;

  // Preset to 1 so an idle active-low pin never looks like an edge.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      sync_q <= '1;
      prev_q <= 1'b1;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], pin_i};
      prev_q <= sync_q[SYNC_STAGES-1];
    end
  end

  assign level_o = sync_q[SYNC_STAGES-1];
  assign fall_o  = prev_q & ~level_o;
  assign rise_o  = ~prev_q & level_o;

endmodule

// File: rtl/ppi_port_a_strobed_ctrl.sv
// Group A Mode 1 strobed I/O handshake for Port A (IBF/OBF/INTR).
// Ports: bus rd_n/wr_n, PC4 stb_n, PC6 ack_n in; latches + PC3/5/7 out.
module ppi_port_a_strobed_ctrl
  import ppi_pkg::*;
#(
  parameter int DATA_W      = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              mode1_en,
  input  logic              dir_in,
  input  logic              inte,
  input  logic              port_a_sel,
  input  logic              rd_n,
  input  logic              wr_n,
  input  logic              stb_n,
  input  logic              ack_n,
  input  logic [DATA_W-1:0] pa_in,
  input  logic [DATA_W-1:0] db_in,
  output logic [DATA_W-1:0] pa_out,
  output logic              pa_oe,
  output logic [DATA_W-1:0] db_out,
  output logic              ibf,
  output logic              obf_n,
  output logic              intr,
  output logic              ovr
);

  logic rd_fall, rd_rise;
  logic wr_fall, wr_rise;
  logic stb_fall, stb_rise;
  logic ack_fall, ack_rise;

  ppi_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_rd (
    .Clk(Clk), .Reset(Reset), .pin_i(rd_n),
    .level_o(), .fall_o(rd_fall), .rise_o(rd_rise)
  );

  ppi_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_wr (
    .Clk(Clk), .Reset(Reset), .pin_i(wr_n),
    .level_o(), .fall_o(wr_fall), .rise_o(wr_rise)
  );

  ppi_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_stb (
    .Clk(Clk), .Reset(Reset), .pin_i(stb_n),
    .level_o(), .fall_o(stb_fall), .rise_o(stb_rise)
  );

  ppi_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_ack (
    .Clk(Clk), .Reset(Reset), .pin_i(ack_n),
    .level_o(), .fall_o(ack_fall), .rise_o(ack_rise)
  );

  // Port A data delayed to line up with the synchronized strobe.
  logic [DATA_W-1:0] pa_dly_q [SYNC_STAGES];

  always_ff @(posedge Clk) begin
    if (Reset) begin
      for (int i = 0; i < SYNC_STAGES; i++) pa_dly_q[i] <= '0;
    end else begin
      pa_dly_q[0] <= pa_in;
      for (int i = 1; i < SYNC_STAGES; i++) pa_dly_q[i] <= pa_dly_q[i-1];
    end
  end

  in_state_t         in_q, in_d;
  out_state_t        out_q, out_d;
  logic [DATA_W-1:0] pa_out_q, pa_out_d;
  logic [DATA_W-1:0] db_out_q, db_out_d;
  logic              ibf_q, ibf_d;
  logic              obf_n_q, obf_n_d;
  logic              intr_q, intr_d;
  logic              ovr_q, ovr_d;
  logic              pa_oe_q;
  logic              mode_q, dir_q;

  logic in_act, out_act, chg;

  assign in_act  = mode1_en & dir_in;
  assign out_act = mode1_en & ~dir_in;
  assign chg     = (mode1_en != mode_q) | (dir_in != dir_q);

  always_comb begin
    in_d     = in_q;
    out_d    = out_q;
    pa_out_d = pa_out_q;
    db_out_d = db_out_q;
    ibf_d    = ibf_q;
    obf_n_d  = obf_n_q;
    intr_d   = intr_q;
    ovr_d    = ovr_q;

    if (chg) begin
      // Mode/direction switch aborts both handshakes; data is kept.
      in_d    = IN_IDLE;
      out_d   = OUT_IDLE;
      ibf_d   = 1'b0;
      ovr_d   = 1'b0;
      intr_d  = 1'b0;
      obf_n_d = 1'b1;
    end else begin
      if (!in_act) begin
        in_d  = IN_IDLE;
        ibf_d = 1'b0;
        ovr_d = 1'b0;
      end else if (stb_fall) begin
        // A new strobe beats everything, including a closing read.
        db_out_d = pa_dly_q[SYNC_STAGES-1];
        ibf_d    = 1'b1;
        if (ibf_q) ovr_d = 1'b1;
        in_d     = IN_CAPT;
      end else begin
        unique case (in_q)
          IN_IDLE: ;
          IN_CAPT: begin
            if (stb_rise) begin
              intr_d = inte;
              in_d   = IN_FULL;
            end
          end
          IN_FULL: begin
            if (rd_fall && port_a_sel) begin
              intr_d = 1'b0;
              in_d   = IN_READ;
            end
          end
          IN_READ: begin
            if (rd_rise && port_a_sel) begin
              ibf_d = 1'b0;
              ovr_d = 1'b0;
              in_d  = IN_IDLE;
            end
          end
        endcase
      end

      if (!out_act) begin
        out_d   = OUT_IDLE;
        obf_n_d = 1'b1;
      end else if (wr_fall && port_a_sel && out_q != OUT_WRITE) begin
        // Writes are taken in IDLE, FULL and ACK alike.
        intr_d = 1'b0;
        out_d  = OUT_WRITE;
      end else begin
        unique case (out_q)
          OUT_IDLE: ;
          OUT_WRITE: begin
            if (wr_rise && port_a_sel) begin
              pa_out_d = db_in;
              obf_n_d  = 1'b0;
              out_d    = OUT_FULL;
            end
          end
          OUT_FULL: begin
            if (ack_fall) begin
              obf_n_d = 1'b1;
              out_d   = OUT_ACK;
            end
          end
          OUT_ACK: begin
            if (ack_rise) begin
              intr_d = inte;
              out_d  = OUT_IDLE;
            end
          end
        endcase
      end

      if (!in_act && !out_act) intr_d = 1'b0;
    end
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      in_q     <= IN_IDLE;
      out_q    <= OUT_IDLE;
      pa_out_q <= '0;
      db_out_q <= '0;
      ibf_q    <= 1'b0;
      obf_n_q  <= 1'b1;
      intr_q   <= 1'b0;
      ovr_q    <= 1'b0;
      pa_oe_q  <= 1'b0;
      // Track the live mode so leaving reset is not seen as a change.
      mode_q   <= mode1_en;
      dir_q    <= dir_in;
    end else begin
      in_q     <= in_d;
      out_q    <= out_d;
      pa_out_q <= pa_out_d;
      db_out_q <= db_out_d;
      ibf_q    <= ibf_d;
      obf_n_q  <= obf_n_d;
      intr_q   <= intr_d;
      ovr_q    <= ovr_d;
      pa_oe_q  <= out_act;
      mode_q   <= mode1_en;
      dir_q    <= dir_in;
    end
  end

  assign pa_out = pa_out_q;
  assign db_out = db_out_q;
  assign pa_oe  = pa_oe_q;
  assign ibf    = ibf_q;
  assign obf_n  = obf_n_q;
  assign intr   = intr_q & inte;
  assign ovr    = ovr_q;

endmodule
